alu_lane_sequencer: RTL and testbench
=====================================

Name: alu_lane_sequencer

Overview:
- Time-multiplexes one scalar ALU (sel-coded add/sub/mul/div, NZVC flags) across the lanes of a vector operation.
- Accepts a vector op (two operand vectors, opcode, lane mask) with a valid/ready handshake.
- Feeds active lanes to the ALU one per cycle, in ascending lane order, and captures each lane's result and flags.
- Presents the assembled result vector with a valid/ready handshake. Sits in Execute between the vector issue stage and the shared ALU.

Parameters:
- WIDTH, 18, lane/ALU data width
- LANES, 4, lanes per vector op (>=1)
- LANE_W, $clog2(LANES) (min 1), lane index width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- in_valid  in  1  vector op offered
- in_ready  out  1  sequencer can accept an op
- in_sel  in  3  ALU opcode: 100 add, 101 sub, 110 div, 111 mul, other = pass A
- in_mask  in  LANES  lane enable, bit i = lane i
- in_a  in  LANES*WIDTH  operand A vector, lane i at [i*WIDTH +: WIDTH]
- in_b  in  LANES*WIDTH  operand B vector
- alu_a  out  WIDTH  to ALU A
- alu_b  out  WIDTH  to ALU B
- alu_sel  out  3  to ALU sel
- alu_out  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_sel)
- alu_nzvc  in  4  ALU flags {N,Z,V,C}
- out_valid  out  1  result vector available
- out_ready  in  1  consumer accepts result
- out_vec  out  LANES*WIDTH  result vector
- out_nzvc  out  LANES*4  per-lane flags
- out_v_any  out  1  OR of V over active lanes
- out_c_any  out  1  OR of C over active lanes
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, RUN, DONE (encoding from package).
- Reset (async, rst=0), from any state including mid-operation:
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - out_vec=0, out_nzvc=0, out_v_any=0, out_c_any=0.
  - alu_a=0, alu_b=0, alu_sel=0.
  - Any in-flight op is discarded.
- IDLE:
  - in_ready=1. On in_valid&&in_ready, register sel, mask, A and B.
  - Preload the result buffer: every lane = A lane, flags 0. Clear both any-flags.
  - If mask!=0: go to RUN with the lane pointer at the lowest set mask bit.
  - If mask==0: go directly to DONE.
- RUN:
  - in_ready=0. alu_a/alu_b = registered lane[ptr]; alu_sel = registered sel. All three are driven from registers.
  - Each cycle: write alu_out and alu_nzvc into buffer lane ptr; OR V/C into the any-flags.
  - Advance ptr to the next set mask bit above ptr. After the highest set bit, go to DONE.
  - Masked-off lanes consume no cycles and keep their preloaded A value and flags 0.
- Latency: k active lanes -> out_valid asserts k+1 cycles after the accept edge; k=0 -> 1 cycle.
- DONE:
  - out_valid=1; outputs stable until out_valid&&out_ready.
  - On that handshake: go to IDLE, out_valid=0. A new op is accepted no earlier than the following cycle (no same-cycle turnaround).
  - If out_ready is held low, stay in DONE indefinitely.
- Outside RUN, alu_sel=0 (ALU pass-A), alu_a/alu_b hold their last values.
- Opcode outside 100..111: lanes are still sequenced; the ALU returns A, and flags are taken from the ALU as presented.
- Width rules:
  - No extension or truncation inside the sequencer. Results are exactly WIDTH bits from the ALU.
  - Lane pointer wrap is impossible because the end is detected by mask scan.

Decomposition:
- Package alu_seq_pkg: state enum (IDLE, RUN, DONE) and opcode constants OP_ADD=3'b100, OP_SUB=3'b101, OP_DIV=3'b110, OP_MUL=3'b111.
- One sub-module, lane_next_finder: combinational; given mask and current ptr, returns the next set lane index above ptr plus a none-left flag. The same module also yields the first set lane (ptr=-1 mode).

Test Plan (WIDTH=18, LANES=4):
- Add, mask=1111, A={1,2,3,5}, B={1,1,1,3}:
  - out_vec={2,3,4,8}, out_valid 5 cycles after accept, all Z=0.
- Sub, lane0 A=3, B=5, mask=0001:
  - lane0=0x3FFFE, N=1, out_valid 2 cycles after accept.
  - lanes1-3 = their A values, flags 0.
- Add, mask=0000:
  - out_valid 1 cycle after accept, out_vec=in_a, all flags 0, alu_sel stays 0.
- Add, mask=1010, lane3 A=0x1FFFF, B=1 (signed overflow):
  - exactly 2 RUN cycles, lane3 V=1, out_v_any=1, lanes 0/2 = A.
- Backpressure: out_ready=0 for 10 cycles:
  - out_valid and out_vec held stable, in_ready=0.
  - Release -> IDLE next cycle; a second op is accepted the following cycle.
- rst low during RUN (after 2 of 4 lanes):
  - immediately IDLE, out_valid=0, in_ready=1.
  - A fresh op after reset produces correct results with no stale lane data.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and opcode constants for the ALU lane sequencer.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } seq_state_e;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_DIV  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

endpackage

// File: rtl/alu_lane_sequencer_if.sv
// Issue-side, ALU-side and result-side signals of the lane sequencer.
interface alu_lane_sequencer_if #(
    parameter int WIDTH = 18,
    parameter int LANES = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [2:0]               in_sel;
    logic [LANES-1:0]         in_mask;
    logic [LANES*WIDTH-1:0]   in_a;
    logic [LANES*WIDTH-1:0]   in_b;

    logic [WIDTH-1:0]         alu_a;
    logic [WIDTH-1:0]         alu_b;
    logic [2:0]               alu_sel;
    logic [WIDTH-1:0]         alu_out;
    logic [3:0]               alu_nzvc;

    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*WIDTH-1:0]   out_vec;
    logic [LANES*4-1:0]       out_nzvc;
    logic                     out_v_any;
    logic                     out_c_any;
    logic                     busy;

    modport slave (
        input  in_valid, in_sel, in_mask, in_a, in_b, alu_out, alu_nzvc, out_ready,
        output in_ready, alu_a, alu_b, alu_sel, out_valid, out_vec, out_nzvc,
               out_v_any, out_c_any, busy
    );

    modport master (
        output in_valid, in_sel, in_mask, in_a, in_b, alu_out, alu_nzvc, out_ready,
        input  in_ready, alu_a, alu_b, alu_sel, out_valid, out_vec, out_nzvc,
               out_v_any, out_c_any, busy
    );

endinterface

// File: rtl/alu_lane_sequencer_next.sv
// Mask scanner: lowest set lane strictly above ptr_i, or lowest set lane overall
// when from_start_i is high. none_o flags that no such lane exists.
module lane_next_finder #(
    parameter int LANES  = 4,
    parameter int LANE_W = 2
) (
    input  logic [LANES-1:0]  mask_i,
    input  logic [LANE_W-1:0] ptr_i,
    input  logic              from_start_i,
    output logic [LANE_W-1:0] idx_o,
    output logic              none_o
);

    // NOTE: combinational logic uses blocking '=' with defaults first, so no latch
    // is inferred; the descending scan lets the lowest qualifying lane win.
    always_comb begin
        idx_o  = '0;
        none_o = 1'b1;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask_i[i] && (from_start_i || (i > int'(ptr_i)))) begin
                idx_o  = LANE_W'(i);
                none_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_lane_sequencer.sv
// Sequences the active lanes of a vector op through one shared scalar ALU,
// one lane per cycle in ascending order, and returns the assembled result.
module alu_lane_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int LANES = 4
) (
    input  logic                clk,
    input  logic                rst,
    alu_lane_sequencer_if.slave bus
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    seq_state_e                    state_q;
    logic                          in_ready_q;
    logic                          out_valid_q;
    logic                          v_any_q;
    logic                          c_any_q;
    logic [2:0]                    alu_sel_q;
    logic [WIDTH-1:0]              alu_a_q;
    logic [WIDTH-1:0]              alu_b_q;
    logic [LANE_W-1:0]             ptr_q;
    logic [LANES-1:0]              mask_q;
    logic [LANES-1:0][WIDTH-1:0]   a_q;
    logic [LANES-1:0][WIDTH-1:0]   b_q;
    logic [LANES-1:0][WIDTH-1:0]   res_q;
    logic [LANES-1:0][3:0]         nzvc_q;

    logic [LANES-1:0][WIDTH-1:0]   in_a_lanes;
    logic [LANES-1:0][WIDTH-1:0]   in_b_lanes;
    logic [LANE_W-1:0]             first_idx;
    logic [LANE_W-1:0]             next_idx;
    logic                          first_none;
    logic                          next_none;
    logic                          accept;

    assign in_a_lanes = bus.in_a;
    assign in_b_lanes = bus.in_b;
    assign accept     = bus.in_valid && in_ready_q;

    lane_next_finder #(.LANES(LANES), .LANE_W(LANE_W)) u_first (
        .mask_i       (bus.in_mask),
        .ptr_i        ('0),
        .from_start_i (1'b1),
        .idx_o        (first_idx),
        .none_o       (first_none)
    );

    lane_next_finder #(.LANES(LANES), .LANE_W(LANE_W)) u_next (
        .mask_i       (mask_q),
        .ptr_i        (ptr_q),
        .from_start_i (1'b0),
        .idx_o        (next_idx),
        .none_o       (next_none)
    );

    // NOTE: operand storage is only read after an accept writes it, so it has no
    // reset and lives in its own block apart from the reset control state.
    always_ff @(posedge clk) begin
        if (accept) begin
            mask_q <= bus.in_mask;
            a_q    <= in_a_lanes;
            b_q    <= in_b_lanes;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            v_any_q     <= 1'b0;
            c_any_q     <= 1'b0;
            alu_sel_q   <= OP_PASS;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            ptr_q       <= '0;
            res_q       <= '0;
            nzvc_q      <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        res_q      <= in_a_lanes;
                        nzvc_q     <= '0;
                        v_any_q    <= 1'b0;
                        c_any_q    <= 1'b0;
                        if (first_none) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q   <= ST_RUN;
                            ptr_q     <= first_idx;
                            alu_a_q   <= in_a_lanes[first_idx];
                            alu_b_q   <= in_b_lanes[first_idx];
                            alu_sel_q <= bus.in_sel;
                        end
                    end
                end
                ST_RUN: begin
                    res_q[ptr_q]  <= bus.alu_out;
                    nzvc_q[ptr_q] <= bus.alu_nzvc;
                    v_any_q       <= v_any_q | bus.alu_nzvc[1];
                    c_any_q       <= c_any_q | bus.alu_nzvc[0];
                    if (next_none) begin
                        state_q   <= ST_DONE;
                        alu_sel_q <= OP_PASS;
                    end else begin
                        ptr_q   <= next_idx;
                        alu_a_q <= a_q[next_idx];
                        alu_b_q <= b_q[next_idx];
                    end
                end
                ST_DONE: begin
                    // Valid rises one cycle after entering DONE, giving k+1 latency.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_sel   = alu_sel_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_vec   = res_q;
    assign bus.out_nzvc  = nzvc_q;
    assign bus.out_v_any = v_any_q;
    assign bus.out_c_any = c_any_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_lane_sequencer.sv
// Directed bench for alu_lane_sequencer with a behavioural scalar ALU attached.
module tb_alu_lane_sequencer;
    import alu_seq_pkg::*;

    localparam int W = 18;
    localparam int L = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    alu_lane_sequencer_if #(.WIDTH(W), .LANES(L)) bus ();

    alu_lane_sequencer #(.WIDTH(W), .LANES(L)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Scalar ALU: C is carry-out on add and borrow on sub; V is signed overflow.
    logic [W:0]   ext;
    logic [W-1:0] res;
    logic         fv, fc;
    always_comb begin
        ext = '0;
        res = bus.alu_a;
        fv  = 1'b0;
        fc  = 1'b0;
        case (bus.alu_sel)
            OP_ADD: begin
                ext = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                res = ext[W-1:0];
                fc  = ext[W];
                fv  = (bus.alu_a[W-1] == bus.alu_b[W-1]) && (res[W-1] != bus.alu_a[W-1]);
            end
            OP_SUB: begin
                ext = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
                res = ext[W-1:0];
                fc  = ext[W];
                fv  = (bus.alu_a[W-1] != bus.alu_b[W-1]) && (res[W-1] != bus.alu_a[W-1]);
            end
            OP_MUL: res = bus.alu_a * bus.alu_b;
            OP_DIV: res = (bus.alu_b == '0) ? '1 : bus.alu_a / bus.alu_b;
            default: res = bus.alu_a;
        endcase
        bus.alu_out  = res;
        bus.alu_nzvc = {res[W-1], (res == '0), fv, fc};
    end

    function automatic logic [L*W-1:0] pack4(input logic [W-1:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one op, then count cycles to out_valid and cycles with a live ALU opcode.
    task automatic run_op(input string tag, input logic [2:0] sel, input logic [L-1:0] mask,
                          input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                          input int exp_lat, input int exp_run);
        int lat;
        int run;
        @(negedge clk);
        check({tag, ".in_ready"}, 128'(bus.in_ready), 128'(1));
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_mask  = mask;
        bus.in_a     = a;
        bus.in_b     = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        run = (bus.alu_sel != OP_PASS) ? 1 : 0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = n;
                break;
            end
            if (bus.alu_sel != OP_PASS) run++;
        end
        check({tag, ".latency"}, 128'(lat), 128'(exp_lat));
        check({tag, ".run_cycles"}, 128'(run), 128'(exp_run));
    endtask

    task automatic check_result(input string tag, input logic [L*W-1:0] vec,
                                input logic [L*4-1:0] nzvc, input logic v_any, input logic c_any);
        check({tag, ".out_vec"}, 128'(bus.out_vec), 128'(vec));
        check({tag, ".out_nzvc"}, 128'(bus.out_nzvc), 128'(nzvc));
        check({tag, ".v_any"}, 128'(bus.out_v_any), 128'(v_any));
        check({tag, ".c_any"}, 128'(bus.out_c_any), 128'(c_any));
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, ".rel_valid"}, 128'(bus.out_valid), 128'(0));
        check({tag, ".rel_ready"}, 128'(bus.in_ready), 128'(1));
        check({tag, ".rel_busy"}, 128'(bus.busy), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [L*W-1:0] held_vec;
        logic           stable;

        bus.in_valid  = 1'b0;
        bus.in_sel    = '0;
        bus.in_mask   = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;

        #23;
        check("reset.in_ready", 128'(bus.in_ready), 128'(1));
        check("reset.out_valid", 128'(bus.out_valid), 128'(0));
        check("reset.busy", 128'(bus.busy), 128'(0));
        check("reset.out_vec", 128'(bus.out_vec), 128'(0));
        check("reset.alu_sel", 128'(bus.alu_sel), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add4", OP_ADD, 4'b1111, pack4(1, 2, 3, 5), pack4(1, 1, 1, 3), 5, 4);
        check_result("add4", pack4(2, 3, 4, 8), 16'h0000, 1'b0, 1'b0);
        release_result("add4");

        run_op("sub1", OP_SUB, 4'b0001, pack4(3, 10, 20, 30), pack4(5, 7, 7, 7), 2, 1);
        check_result("sub1", pack4(18'h3FFFE, 10, 20, 30), 16'h0009, 1'b0, 1'b1);
        check("sub1.lane0_n", 128'(bus.out_nzvc[3]), 128'(1));
        release_result("sub1");

        run_op("mask0", OP_ADD, 4'b0000, pack4(7, 8, 9, 10), pack4(1, 1, 1, 1), 1, 0);
        check_result("mask0", pack4(7, 8, 9, 10), 16'h0000, 1'b0, 1'b0);
        check("mask0.alu_sel", 128'(bus.alu_sel), 128'(0));
        release_result("mask0");

        run_op("ovf", OP_ADD, 4'b1010, pack4(18'h11, 18'h22, 18'h33, 18'h1FFFF),
               pack4(1, 2, 3, 1), 3, 2);
        check_result("ovf", pack4(18'h11, 18'h24, 18'h33, 18'h20000), 16'hA000, 1'b1, 1'b0);
        release_result("ovf");

        run_op("bp", OP_MUL, 4'b0110, pack4(0, 3, 4, 0), pack4(0, 5, 6, 0), 3, 2);
        check_result("bp", pack4(0, 15, 24, 0), 16'h0000, 1'b0, 1'b0);
        held_vec = bus.out_vec;
        stable   = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            if (!bus.out_valid || bus.in_ready || (bus.out_vec !== held_vec)) stable = 1'b0;
        end
        check("bp.held_stable", 128'(stable), 128'(1));
        release_result("bp");
        run_op("div", OP_DIV, 4'b0001, pack4(100, 1, 2, 3), pack4(7, 1, 1, 1), 2, 1);
        check_result("div", pack4(14, 1, 2, 3), 16'h0000, 1'b0, 1'b0);
        release_result("div");

        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sel   = OP_ADD;
        bus.in_mask  = 4'b1111;
        bus.in_a     = pack4(18'h100, 18'h200, 18'h300, 18'h400);
        bus.in_b     = pack4(1, 1, 1, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid.out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_mid.in_ready", 128'(bus.in_ready), 128'(1));
        check("rst_mid.busy", 128'(bus.busy), 128'(0));
        check("rst_mid.out_vec", 128'(bus.out_vec), 128'(0));
        check("rst_mid.alu_a", 128'(bus.alu_a), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_op("post_rst", OP_SUB, 4'b1100, pack4(1, 2, 10, 4), pack4(9, 9, 3, 4), 3, 2);
        check_result("post_rst", pack4(1, 2, 7, 0), 16'h4000, 1'b0, 1'b0);
        release_result("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
